// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and the ARM-subset datapath.
// Carries the instruction fields and ALU flags that the datapath presents,
// the memory handshake, and every select/enable the controller drives back.
//   master : the control unit (drives the controls, samples the instruction and flags)
//   slave  : the datapath / memory side
interface multicycle_control_unit_if;
  // datapath -> controller
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       MemReady;
  // controller -> datapath
  logic       PCSrc;
  logic       MemtoReg;
  logic       ALUSrc;
  logic       RegWrite;
  logic [3:0] ALUControl;
  logic [1:0] ImmSrc;
  logic [2:0] RegSrc;
  logic       PCWrite;
  logic       MemRead;
  logic       MemWrite;
  logic [3:0] Flags;
  logic [1:0] State;
  logic       Fault;

  modport master (
    input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
    output PCSrc, MemtoReg, ALUSrc, RegWrite, ALUControl, ImmSrc, RegSrc,
           PCWrite, MemRead, MemWrite, Flags, State, Fault
  );

  modport slave (
    output Cond, Op, Funct, Rd, ALUFlags, MemReady,
    input  PCSrc, MemtoReg, ALUSrc, RegWrite, ALUControl, ImmSrc, RegSrc,
           PCWrite, MemRead, MemWrite, Flags, State, Fault
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle sequencing controller for the ARM-subset datapath.
// Decodes DP / branch / LDR-STR (immediate offset) instructions, evaluates the
// condition field against the stored NZCV flags and walks the datapath through
// FETCH -> EXEC (-> MEM) -> FETCH. A data-memory access that never completes
// within TIMEOUT MEM cycles parks the unit in FAULT until reset.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - control bus (master side): instruction fields, ALU flags and
//          MemReady in; datapath selects/enables, Flags, State, Fault out
module multicycle_control_unit #(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  multicycle_control_unit_if.master bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] FETCH = 2'b00;
  localparam logic [1:0] EXEC  = 2'b01;
  localparam logic [1:0] MEM   = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_ORR  = 4'b0011;
  localparam logic [3:0] ALU_EOR  = 4'b0100;
  localparam logic [3:0] ALU_MOVB = 4'b0101;

  logic [1:0]    state, state_n;
  logic [3:0]    flags;
  logic [CW-1:0] cnt;

  // ---------------------------------------------------------------- condition
  logic fn, fz, fc, fv;
  logic condex;
  assign {fn, fz, fc, fv} = flags;

  always_comb begin
    condex = 1'b0;
    case (bus.Cond)
      4'b0000: condex = fz;
      4'b0001: condex = ~fz;
      4'b0010: condex = fc;
      4'b0011: condex = ~fc;
      4'b0100: condex = fn;
      4'b0101: condex = ~fn;
      4'b0110: condex = fv;
      4'b0111: condex = ~fv;
      4'b1000: condex = fc & ~fz;
      4'b1001: condex = ~fc | fz;
      4'b1010: condex = (fn == fv);
      4'b1011: condex = (fn != fv);
      4'b1100: condex = ~fz & (fn == fv);
      4'b1101: condex = fz | (fn != fv);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------ decode
  logic [3:0] cmd;
  logic       is_cmp, dp_ok, mem_ok, is_b, is_ldr;
  logic [3:0] dp_alu;
  logic [3:0] mem_alu;
  logic       taken;

  assign cmd    = bus.Funct[4:1];
  assign is_cmp = (cmd == 4'b1010);
  assign is_b   = (bus.Op == 2'b10);
  assign mem_ok = (bus.Op == 2'b01) & ~bus.Funct[5];
  assign is_ldr = bus.Funct[0];
  // U bit selects whether the offset is added or subtracted
  assign mem_alu = bus.Funct[3] ? ALU_ADD : ALU_SUB;

  always_comb begin
    dp_ok  = (bus.Op == 2'b00);
    dp_alu = ALU_ADD;
    case (cmd)
      4'b0000: dp_alu = ALU_AND;
      4'b0001: dp_alu = ALU_EOR;
      4'b0010: dp_alu = ALU_SUB;
      4'b0100: dp_alu = ALU_ADD;
      4'b1100: dp_alu = ALU_ORR;
      4'b1010: dp_alu = ALU_SUB;
      4'b1101: dp_alu = ALU_MOVB;
      default: dp_ok  = 1'b0;
    endcase
  end

  // Unsupported encodings fall through the same path as a failed condition.
  assign taken = condex & (dp_ok | is_b | mem_ok);

  // ----------------------------------------------------------------- outputs
  logic       pcsrc, memtoreg, alusrc, regwrite, pcwrite, memread, memwrite;
  logic [3:0] aluctl;
  logic [1:0] immsrc;
  logic [2:0] regsrc;
  logic       flag_we;

  always_comb begin
    state_n  = state;
    pcsrc    = 1'b0;
    memtoreg = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    pcwrite  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    aluctl   = 4'b0000;
    immsrc   = 2'b00;
    regsrc   = 3'b000;
    flag_we  = 1'b0;
    case (state)
      FETCH: state_n = EXEC;
      EXEC: begin
        state_n = FETCH;
        if (!taken) begin
          pcwrite = 1'b1;
        end else if (dp_ok) begin
          alusrc   = bus.Funct[5];
          aluctl   = dp_alu;
          regwrite = ~is_cmp;
          pcwrite  = 1'b1;
          pcsrc    = ~is_cmp & (bus.Rd == 4'd15);
          flag_we  = bus.Funct[0] | is_cmp;
        end else if (is_b) begin
          immsrc  = 2'b10;
          alusrc  = 1'b1;
          regsrc  = 3'b001;
          aluctl  = ALU_ADD;
          pcsrc   = 1'b1;
          pcwrite = 1'b1;
        end else begin
          // address computation only; the access itself happens in MEM
          immsrc  = 2'b01;
          alusrc  = 1'b1;
          aluctl  = mem_alu;
          regsrc  = {~is_ldr, 2'b00};
          state_n = MEM;
        end
      end
      MEM: begin
        // instruction register is stable, so the address controls re-decode
        // to the same values they had in EXEC
        immsrc   = 2'b01;
        alusrc   = 1'b1;
        aluctl   = mem_alu;
        regsrc   = {~is_ldr, 2'b00};
        memread  = is_ldr;
        memwrite = ~is_ldr;
        if (bus.MemReady) begin
          pcwrite  = 1'b1;
          regwrite = is_ldr;
          memtoreg = is_ldr;
          pcsrc    = is_ldr & (bus.Rd == 4'd15);
          state_n  = FETCH;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state_n = FAULT;
        end
      end
      default: state_n = FAULT;
    endcase
  end

  // ------------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      flags <= 4'b0000;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (flag_we) flags <= bus.ALUFlags;
      if (state == EXEC)
        cnt <= '0;
      else if (state == MEM && !bus.MemReady)
        cnt <= cnt + CW'(1);
    end
  end

  assign bus.PCSrc      = pcsrc;
  assign bus.MemtoReg   = memtoreg;
  assign bus.ALUSrc     = alusrc;
  assign bus.RegWrite   = regwrite;
  assign bus.ALUControl = aluctl;
  assign bus.ImmSrc     = immsrc;
  assign bus.RegSrc     = regsrc;
  assign bus.PCWrite    = pcwrite;
  assign bus.MemRead    = memread;
  assign bus.MemWrite   = memwrite;
  assign bus.Flags      = flags;
  assign bus.State      = state;
  assign bus.Fault      = (state == FAULT);

endmodule
